// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: scan-control and multiplexer-side signals of mux_scan_ctrl.
// change/change_mask exist only when SCAN_CHANGE_DET_EN is defined.
interface mux_scan_ctrl_if;
   logic       start;
   logic       continuous;
   logic [3:0] ch_mask;
   logic [1:0] MUX_sel;
   logic       MUX_out;
   logic [3:0] scan_data;
   logic       valid;
   logic       busy;
   logic       done;
`ifdef SCAN_CHANGE_DET_EN
   logic       change;
   logic [3:0] change_mask;

   modport master (
      output start, continuous, ch_mask, MUX_out,
      input  MUX_sel, scan_data, valid, busy, done,
      input  change, change_mask
   );

   modport slave (
      input  start, continuous, ch_mask, MUX_out,
      output MUX_sel, scan_data, valid, busy, done,
      output change, change_mask
   );
`else
   modport master (
      output start, continuous, ch_mask, MUX_out,
      input  MUX_sel, scan_data, valid, busy, done
   );

   modport slave (
      input  start, continuous, ch_mask, MUX_out,
      output MUX_sel, scan_data, valid, busy, done
   );
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: settle/sample sequencer in front of a 4:1 bit multiplexer.
// Optional scan-to-scan change detection enabled by macro SCAN_CHANGE_DET_EN.
module mux_scan_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 8
) (
   input  logic           clk,
   input  logic           rst,
   mux_scan_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [3:0]       mask, mask_d;
   logic [3:0]       shadow, shadow_d;
   logic [1:0]       sel, sel_d;
   logic [3:0]       data, data_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [2:0]       nxt;
`ifdef SCAN_CHANGE_DET_EN
   logic             chg_q, chg_d;
   logic [3:0]       cmask_q, cmask_d;
   logic [3:0]       diff;
`endif

   function automatic logic [1:0] low_ch(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) r = 2'(i);
      end
      return r;
   endfunction

   // {found, index} of the lowest enabled channel above cur
   function automatic logic [2:0] next_ch(input logic [3:0] m,
                                          input logic [1:0] cur);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // next state and next values of every registered output
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      mask_d   = mask;
      shadow_d = shadow;
      sel_d    = sel;
      data_d   = data;
      valid_d  = valid_q;
      done_d   = 1'b0;
      nxt      = 3'b000;
`ifdef SCAN_CHANGE_DET_EN
      chg_d    = 1'b0;
      cmask_d  = cmask_q;
      diff     = 4'b0000;
`endif
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               if (|bus.ch_mask) begin
                  mask_d  = bus.ch_mask;
                  sel_d   = low_ch(bus.ch_mask);
                  cnt_d   = '0;
                  state_d = SETTLE;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         SETTLE: begin
            cnt_d = cnt + 1'b1;
            if (cnt == CNT_LAST) state_d = SAMPLE;
         end
         SAMPLE: begin
            shadow_d[sel] = bus.MUX_out;
            nxt           = next_ch(mask, sel);
            if (nxt[2]) begin
               sel_d   = nxt[1:0];
               cnt_d   = '0;
               state_d = SETTLE;
            end else begin
               // publish on entry to DONE so data and done align
               data_d  = shadow_d;
               valid_d = 1'b1;
               done_d  = 1'b1;
               state_d = DONE;
`ifdef SCAN_CHANGE_DET_EN
               diff    = (shadow_d ^ data) & mask;
               cmask_d = diff;
               chg_d   = valid_q && (|diff);
`endif
            end
         end
         DONE: begin
            if (bus.continuous && (|bus.ch_mask)) begin
               mask_d  = bus.ch_mask;
               sel_d   = low_ch(bus.ch_mask);
               cnt_d   = '0;
               state_d = SETTLE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         mask    <= 4'b0000;
         shadow  <= 4'b0000;
         sel     <= 2'd0;
         data    <= 4'b0000;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         cnt     <= cnt_d;
         mask    <= mask_d;
         shadow  <= shadow_d;
         sel     <= sel_d;
         data    <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef SCAN_CHANGE_DET_EN
   // change flag and per-channel change mask
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chg_q   <= 1'b0;
         cmask_q <= 4'b0000;
      end else begin
         chg_q   <= chg_d;
         cmask_q <= cmask_d;
      end
   end

   assign bus.change      = chg_q;
   assign bus.change_mask = cmask_q;
`endif

   assign bus.MUX_sel   = sel;
   assign bus.scan_data = data;
   assign bus.valid     = valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench for mux_scan_ctrl.
// A behavioural 4:1 mux drives MUX_out from mux_in and MUX_sel.
module tb_mux_scan_ctrl;

   localparam int S = 2;

   typedef struct {
      logic [3:0] data;
      logic       vld;
      logic       chg;
      logic [3:0] cm;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] mux_in = 4'b0000;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   exp_t       q[$];
   logic [3:0] m_data = 4'b0000;
   logic       m_valid = 1'b0;
   logic [3:0] m_cm = 4'b0000;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mux_scan_ctrl_if bus ();

   mux_scan_ctrl #(
      .SETTLE_CYCLES(S),
      .CNT_W        (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   assign bus.MUX_out = mux_in[bus.MUX_sel];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // reference model of one scan; updates the bench-side state
   task automatic push_exp(input logic [3:0] mask, input logic [3:0] mux,
                           input int at);
      exp_t       e;
      logic [3:0] nd;
      logic [3:0] df;
      e.cyc = at;
      if (mask == 4'b0000) begin
         e.data = m_data;
         e.vld  = m_valid;
         e.chg  = 1'b0;
         e.cm   = m_cm;
      end else begin
         nd      = (m_data & ~mask) | (mux & mask);
         df      = (nd ^ m_data) & mask;
         e.data  = nd;
         e.vld   = 1'b1;
         e.chg   = m_valid && (|df);
         e.cm    = df;
         m_data  = nd;
         m_valid = 1'b1;
         m_cm    = df;
      end
      q.push_back(e);
   endtask

   // done monitor: pop and compare
   always @(negedge clk) begin : mon
      exp_t e;
      if (bus.done) begin
         if (q.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("scan_data", bus.scan_data, e.data);
            chk("valid", bus.valid, e.vld);
            chk("done_cyc", cyc, e.cyc);
`ifdef SCAN_CHANGE_DET_EN
            chk("change", bus.change, e.chg);
            chk("change_mask", bus.change_mask, e.cm);
`endif
         end
      end
   end

   task automatic wait_drain();
      @(negedge clk);
      for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
      chk("drain", q.size(), 0);
      q.delete();
   endtask

   task automatic run_scan(input logic [3:0] mask, input logic [3:0] mux,
                           input bit chk_sel);
      int n;
      int ch[4];
      int lat;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         ch[i] = 0;
         if (mask[i]) begin
            ch[n] = i;
            n++;
         end
      end
      lat         = n * (S + 1);
      mux_in      = mux;
      bus.ch_mask = mask;
      push_exp(mask, mux, cyc + 1 + lat);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int t = 0; t < lat; t++) begin
         if (chk_sel) chk("mux_sel", bus.MUX_sel, ch[t / (S + 1)]);
         chk("busy_scan", bus.busy, 1);
         @(negedge clk);
      end
      chk("busy_end", bus.busy, (n != 0) ? 32'd1 : 32'd0);
      wait_drain();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_sel"}, bus.MUX_sel, 0);
      chk({tag, "_data"}, bus.scan_data, 0);
      chk({tag, "_valid"}, bus.valid, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
`ifdef SCAN_CHANGE_DET_EN
      chk({tag, "_chg"}, bus.change, 0);
      chk({tag, "_cmask"}, bus.change_mask, 0);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start      = 1'b0;
      bus.continuous = 1'b0;
      bus.ch_mask    = 4'b0000;
      repeat (3) @(negedge clk);
      chk_zero("rst");
      rst = 1'b0;
      @(negedge clk);

      // full scan, then a partial mask over an all-ones snapshot
      run_scan(4'b1111, 4'b1010, 1'b1);
      run_scan(4'b1111, 4'b1111, 1'b0);
      run_scan(4'b0101, 4'b0000, 1'b1);

      // empty mask: immediate done, nothing else moves
      run_scan(4'b0000, 4'b0110, 1'b0);
      repeat (3) @(negedge clk);
      chk("mask0_busy", bus.busy, 0);

      // continuous mode, two scans then stop; extra start ignored
      mux_in      = 4'b0001;
      bus.ch_mask = 4'b0011;
      push_exp(4'b0011, 4'b0001, cyc + 1 + 6);
      push_exp(4'b0011, 4'b0010, cyc + 1 + 6 + 7);
      bus.continuous = 1'b1;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 50 && q.size() > 1; i++) @(negedge clk);
      chk("cont_first", q.size(), 1);
      mux_in = 4'b0010;
      @(negedge clk);
      bus.continuous = 1'b0;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_drain();
      repeat (15) @(negedge clk);
      chk("cont_idle", bus.busy, 0);

      // reset in the middle of channel 2 settle
      bus.ch_mask = 4'b1111;
      mux_in      = 4'b1111;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 50 && bus.MUX_sel != 2'd2; i++) @(negedge clk);
      chk("reach_ch2", bus.MUX_sel, 2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_zero("midrst");
      m_data  = 4'b0000;
      m_valid = 1'b0;
      m_cm    = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // first scan after reset never flags change; second does
      run_scan(4'b1111, 4'b0001, 1'b1);
      run_scan(4'b1111, 4'b0011, 1'b0);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
